credit_counter: RTL

CREDIT_COUNTER -- requirements
Module: credit_counter

---
 rtl/credit_counter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/credit_counter.sv
`default_nettype none
// ============================================================================
// Module      : credit_counter
// Description : Coin debounce, credit accounting with start deduction,
//               credit flags and a paced coin-meter pulse generator.
// Revision    : 1.0
// ============================================================================
module credit_counter #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int METER_CYCLES    = 1024,
    parameter int MAX_CREDITS     = 15
) (
    input  logic       CLK_DRV,
    input  logic       RESET,
    input  logic       COIN1_N,
    input  logic       COIN2_N,
    input  logic       START_GAME,
    input  logic       _2_CR_START,
    input  logic       COIN_MODE,
    input  logic       FREE_PLAY,
    output logic       _1_OR_2_CREDIT_N,
    output logic       _2_CREDIT_N,
    output logic [3:0] CREDITS,
    output logic       COIN_LOCKOUT,
    output logic       COIN_METER
);

    localparam int                        c_DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int                        c_MET_W    = $clog2(METER_CYCLES + 1);
    localparam logic [c_DEB_W-1:0]        c_DEB_LAST = c_DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DEB_W-1:0]        c_DEB_ONE  = c_DEB_W'(1);
    localparam logic [c_MET_W-1:0]        c_MET_LAST = c_MET_W'(METER_CYCLES - 1);
    localparam logic [c_MET_W-1:0]        c_MET_ONE  = c_MET_W'(1);
    localparam logic [3:0]                c_MAX4     = 4'(MAX_CREDITS);
    localparam logic signed [6:0]         c_MAX7     = 7'(MAX_CREDITS);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_PULSE = 1'b1
    } meter_state_t;

    logic [1:0] w_coin_n;
    logic [1:0] w_coin_evt;

    assign w_coin_n = {COIN2_N, COIN1_N};

    // Each debouncer alternates between waiting for a stable low (armed) and
    // waiting for a stable high (disarmed); the count restarts on any mismatch.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_deb
            logic               armed_q, armed_d;
            logic               event_q, event_d;
            logic [c_DEB_W-1:0] cnt_q, cnt_d;
            logic               w_match;

            always_comb begin
                armed_d = armed_q;
                event_d = 1'b0;
                cnt_d   = cnt_q;
                w_match = armed_q ? ~w_coin_n[gi] : w_coin_n[gi];
                if (!w_match) begin
                    cnt_d = '0;
                end else if (cnt_q == c_DEB_LAST) begin
                    cnt_d   = '0;
                    armed_d = ~armed_q;
                    event_d = armed_q;
                end else begin
                    cnt_d = cnt_q + c_DEB_ONE;
                end
            end

            always_ff @(posedge CLK_DRV) begin
                if (RESET) begin
                    armed_q <= 1'b0;
                    event_q <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    armed_q <= armed_d;
                    event_q <= event_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign w_coin_evt[gi] = event_q;
        end
    endgenerate

    logic [3:0]        credits_q, credits_d;
    logic              start_q, start_d;
    logic              one_n_q, one_n_d;
    logic              two_n_q, two_n_d;
    logic [1:0]        pending_q, pending_d;
    logic [c_MET_W-1:0] mcnt_q, mcnt_d;
    meter_state_t      state_q, state_d;

    logic [1:0]        w_n_evt;
    logic [2:0]        w_add;
    logic [1:0]        w_sub;
    logic              w_start_edge;
    logic signed [6:0] w_sum;
    logic              w_dec;
    logic [2:0]        w_pend_sum;

    always_comb begin
        w_n_evt      = {1'b0, w_coin_evt[0]} + {1'b0, w_coin_evt[1]};
        w_add        = COIN_MODE ? {w_n_evt, 1'b0} : {1'b0, w_n_evt};
        w_start_edge = START_GAME & ~start_q;
        w_sub        = 2'd0;
        if (w_start_edge && !FREE_PLAY) begin
            w_sub = _2_CR_START ? 2'd2 : 2'd1;
        end
        w_sum = $signed({3'b000, credits_q}) + $signed({4'b0000, w_add})
              - $signed({5'b00000, w_sub});
        if (w_sum < 7'sd0) begin
            credits_d = 4'd0;
        end else if (w_sum > c_MAX7) begin
            credits_d = c_MAX4;
        end else begin
            credits_d = w_sum[3:0];
        end
        start_d = START_GAME;
        // Flags follow the registered count, so they trail CREDITS by a clock.
        one_n_d = ~(FREE_PLAY | (credits_q != 4'd0));
        two_n_d = ~(FREE_PLAY | (credits_q >= 4'd2));
    end

    // Meter pacing: IDLE always lasts at least one clock between pulses.
    always_comb begin
        state_d = state_q;
        mcnt_d  = mcnt_q;
        w_dec   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pending_q != 2'd0) begin
                    state_d = ST_PULSE;
                    mcnt_d  = '0;
                    w_dec   = 1'b1;
                end
            end
            ST_PULSE: begin
                if (mcnt_q == c_MET_LAST) begin
                    state_d = ST_IDLE;
                    mcnt_d  = '0;
                end else begin
                    mcnt_d = mcnt_q + c_MET_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                mcnt_d  = '0;
            end
        endcase
        w_pend_sum = {1'b0, pending_q} - {2'b00, w_dec} + {1'b0, w_n_evt};
        pending_d  = (w_pend_sum > 3'd3) ? 2'd3 : w_pend_sum[1:0];
    end

    always_ff @(posedge CLK_DRV) begin
        if (RESET) begin
            credits_q <= 4'd0;
            start_q   <= 1'b0;
            one_n_q   <= ~FREE_PLAY;
            two_n_q   <= ~FREE_PLAY;
            pending_q <= 2'd0;
            mcnt_q    <= '0;
            state_q   <= ST_IDLE;
        end else begin
            credits_q <= credits_d;
            start_q   <= start_d;
            one_n_q   <= one_n_d;
            two_n_q   <= two_n_d;
            pending_q <= pending_d;
            mcnt_q    <= mcnt_d;
            state_q   <= state_d;
        end
    end

    assign CREDITS          = credits_q;
    assign COIN_LOCKOUT     = (credits_q == c_MAX4);
    assign COIN_METER       = (state_q == ST_PULSE);
    assign _1_OR_2_CREDIT_N = one_n_q;
    assign _2_CREDIT_N      = two_n_q;

endmodule
`default_nettype wire
